// File: rtl/t06_snake_pkg.sv
// Shared types for the snake core: heading encodings, game run state and heading reversal.
package t06_snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DEAD   = 2'b11
  } game_state_t;

  // Opposite headings differ only in bit 0 (UP<->DOWN, LEFT<->RIGHT).
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/t06_dir_queue.sv
// Small synchronous FIFO of pending headings with flush, head/tail peek and occupancy count.
module t06_dir_queue
  import t06_snake_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  dir_t                     din,
  output dir_t                     head,
  output dir_t                     tail,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;
  dir_t          mem [DEPTH];

  assign full    = (cnt == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - PW'(1)];
  assign count = cnt;

endmodule

// File: rtl/t06_move_scheduler.sv
// Movement tick generator, game run-state FSM and buffered direction input for the snake core.
// Optional T06_SPEEDUP_EN: tick period shrinks with speed_level (TICK_DIV >> speed_level, min 2).
module t06_move_scheduler
  import t06_snake_pkg::*;
#(
  parameter int unsigned      DIV_W    = 24,
  parameter logic [DIV_W-1:0] TICK_DIV = DIV_W'(1_000_000),
  parameter int unsigned      QDEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic                     pause_btn,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  input  logic                     bad_collision,
  input  logic [2:0]               speed_level,
  output logic                     tick,
  output logic [1:0]               direction,
  output logic [1:0]               state,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic                     game_over
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  game_state_t      state_q;
  dir_t             dir_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] period;
  dir_t             cand;
  dir_t             last;
  dir_t             q_head;
  dir_t             q_tail;
  logic             cand_vld;
  logic             run;
  logic             advance;
  logic             terminal;
  logic             accept;
  logic             do_pop;
  logic             flush;
  logic             q_full;
  logic [CW-1:0]    q_cnt;

  // Press decode: one candidate per cycle, up > right > down > left.
  always_comb begin
    cand     = DIR_UP;
    cand_vld = 1'b1;
    if (up)         cand = DIR_UP;
    else if (right) cand = DIR_RIGHT;
    else if (down)  cand = DIR_DOWN;
    else if (left)  cand = DIR_LEFT;
    else            cand_vld = 1'b0;
  end

  assign run      = (state_q == ST_RUN);
  assign advance  = run && !bad_collision && !pause_btn;
  assign terminal = (cnt_q == period - DIV_W'(1));
  assign last     = (q_cnt != '0) ? q_tail : dir_q;
  assign accept   = run && !bad_collision && cand_vld && !q_full &&
                    (cand != last) && (cand != dir_reverse(last));
  assign do_pop   = advance && terminal && (q_cnt != '0);
  assign flush    = (run && bad_collision) || ((state_q == ST_DEAD) && start);

`ifdef T06_SPEEDUP_EN
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_nxt;

  always_comb begin
    period_nxt = TICK_DIV >> speed_level;
    if (period_nxt < DIV_W'(2)) period_nxt = DIV_W'(2);
  end

  // Period is latched at game start and at every counter wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      period_q <= TICK_DIV;
    else if (((state_q == ST_IDLE) && start) || (advance && terminal))
      period_q <= period_nxt;
  end

  assign period = period_q;
`else
  logic unused_speed;
  assign unused_speed = ^speed_level;
  assign period       = TICK_DIV;
`endif

  t06_dir_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .nrst  (nrst),
    .push  (accept),
    .pop   (do_pop),
    .flush (flush),
    .din   (cand),
    .head  (q_head),
    .tail  (q_tail),
    .full  (q_full),
    .count (q_cnt)
  );

  // Run-state FSM; collision outranks pause and terminal count, pause freezes the phase.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      cnt_q     <= '0;
      tick      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bad_collision) begin
            state_q   <= ST_DEAD;
            game_over <= 1'b1;
            dir_q     <= DIR_RIGHT;
            cnt_q     <= '0;
          end else if (pause_btn) begin
            state_q <= ST_PAUSED;
          end else if (terminal) begin
            cnt_q <= '0;
            tick  <= 1'b1;
            if (do_pop) dir_q <= q_head;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        ST_PAUSED: begin
          if (pause_btn) state_q <= ST_RUN;
        end
        ST_DEAD: begin
          if (start) begin
            state_q   <= ST_IDLE;
            game_over <= 1'b0;
            dir_q     <= DIR_RIGHT;
            cnt_q     <= '0;
          end
        end
      endcase
    end
  end

  assign state     = state_q;
  assign direction = dir_q;
  assign q_count   = q_cnt;

endmodule

// File: tb/tb_t06_move_scheduler.sv
// Scoreboard bench for t06_move_scheduler with TICK_DIV=8, QDEPTH=4.
module tb_t06_move_scheduler;

  localparam int P_UP    = 0;
  localparam int P_DOWN  = 1;
  localparam int P_LEFT  = 2;
  localparam int P_RIGHT = 3;
  localparam int P_START = 4;
  localparam int P_PAUSE = 5;
  localparam int P_COLL  = 6;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       pause_btn = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       bad_collision = 1'b0;
  logic [2:0] speed_level = 3'd0;
  logic       tick;
  logic [1:0] direction;
  logic [1:0] state;
  logic [2:0] q_count;
  logic       game_over;

  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_dir = 2'b11;

  always #5 clk = ~clk;

  t06_move_scheduler #(
    .DIV_W    (24),
    .TICK_DIV (24'd8),
    .QDEPTH   (4)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .pause_btn     (pause_btn),
    .up            (up),
    .down          (down),
    .left          (left),
    .right         (right),
    .bad_collision (bad_collision),
    .speed_level   (speed_level),
    .tick          (tick),
    .direction     (direction),
    .state         (state),
    .q_count       (q_count),
    .game_over     (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle pulse driven at a falling edge, sampled by the following rising edge.
  task automatic press(input int which);
    case (which)
      P_UP:    up = 1'b1;
      P_DOWN:  down = 1'b1;
      P_LEFT:  left = 1'b1;
      P_RIGHT: right = 1'b1;
      P_START: start = 1'b1;
      P_PAUSE: pause_btn = 1'b1;
      default: bad_collision = 1'b1;
    endcase
    @(negedge clk);
    {up, down, left, right, start, pause_btn, bad_collision} = '0;
  endtask

  // Waits (bounded) for a tick, then pops the scoreboard and checks the heading.
  task automatic wait_tick(input string tag, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      seen = tick;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (exp_q.size() > 0) exp_dir = exp_q.pop_front();
      check({tag, "_dir"}, 32'(direction), 32'(exp_dir));
    end
  endtask

  initial begin
    int cyc;
    int ticks;

    repeat (2) @(negedge clk);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_dir", 32'(direction), 32'd3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_qcount", 32'(q_count), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    press(P_START);
    check("start_state", 32'(state), 32'd1);
    wait_tick("t1", cyc);
    check("first_tick_lat", 32'(cyc), 32'd8);
    wait_tick("t2", cyc);
    check("tick_period", 32'(cyc), 32'd8);

    // Reverse and same-heading presses are rejected.
    press(P_LEFT);
    check("rej_reverse", 32'(q_count), 32'd0);
    press(P_RIGHT);
    check("rej_same", 32'(q_count), 32'd0);
    wait_tick("t3", cyc);

    // Two presses in one tick are applied on successive ticks.
    press(P_UP);   exp_q.push_back(2'b00);
    press(P_LEFT); exp_q.push_back(2'b10);
    check("two_queued", 32'(q_count), 32'd2);
    wait_tick("t4", cyc);
    check("after_t4_q", 32'(q_count), 32'd1);
    wait_tick("t5", cyc);
    check("after_t5_q", 32'(q_count), 32'd0);

    // Fifth valid press is dropped on a full queue.
    press(P_UP);    exp_q.push_back(2'b00);
    press(P_LEFT);  exp_q.push_back(2'b10);
    press(P_DOWN);  exp_q.push_back(2'b01);
    press(P_RIGHT); exp_q.push_back(2'b11);
    press(P_UP);
    check("q_full", 32'(q_count), 32'd4);
    wait_tick("t6", cyc);
    wait_tick("t7", cyc);
    wait_tick("t8", cyc);
    wait_tick("t9", cyc);
    wait_tick("t10", cyc);
    check("drained_q", 32'(q_count), 32'd0);

    // Pause at counter=5 for 20 cycles, then resume.
    repeat (5) @(negedge clk);
    press(P_PAUSE);
    check("paused_state", 32'(state), 32'd2);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    check("pause_no_tick", 32'(ticks), 32'd0);
    press(P_PAUSE);
    check("resume_state", 32'(state), 32'd1);
    wait_tick("resume", cyc);
    check("resume_lat", 32'(cyc), 32'd3);

    // Collision on the terminal count beats tick and pop.
    press(P_UP);
    check("pre_coll_q", 32'(q_count), 32'd1);
    repeat (6) @(negedge clk);
    press(P_COLL);
    exp_q.delete();
    exp_dir = 2'b11;
    check("dead_state", 32'(state), 32'd3);
    check("dead_game_over", 32'(game_over), 32'd1);
    check("dead_no_tick", 32'(tick), 32'd0);
    check("dead_qcount", 32'(q_count), 32'd0);
    check("dead_dir", 32'(direction), 32'd3);
    press(P_UP);
    check("dead_press_ignored", 32'(q_count), 32'd0);
    press(P_START);
    check("restart_idle", 32'(state), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    press(P_START);
    check("rerun_state", 32'(state), 32'd1);
    wait_tick("rerun", cyc);
    check("rerun_lat", 32'(cyc), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/t06_move_scheduler.md
# t06_move_scheduler

Game-tick scheduler and direction-input buffer for the snake core. It generates the periodic movement tick that advances the snake and owns the game run state (idle/run/paused/dead). It queues player button presses so that several presses inside one tick are applied one per tick, with no press lost. It replaces free-running direction sampling: downstream body/collision logic consumes `tick` and `direction` only.

## Interface
Parameters:
- `TICK_DIV`, 24'd1_000_000, clk cycles per movement tick at speed level 0
- `DIV_W`, 24, tick counter width
- `QDEPTH`, 4, direction queue depth (power of 2, ≥2)

Ports (reset nrst, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock
- `nrst`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle pulse, start/restart game
- `pause_btn`  in  1  single-cycle pulse, toggle pause
- `up`, `down`, `left`, `right`  in  1 each  single-cycle press pulses (debounced/edge-detected upstream)
- `bad_collision`  in  1  level, snake hit wall/body
- `speed_level`  in  3  speed index (used only with `T06_SPEEDUP_EN`)
- `tick`  out  1  registered one-cycle movement pulse
- `direction`  out  2  current heading: UP=00, DOWN=01, LEFT=10, RIGHT=11
- `state`  out  2  IDLE=00, RUN=01, PAUSED=10, DEAD=11
- `q_count`  out  $clog2(QDEPTH)+1  queued direction entries
- `game_over`  out  1  high while state==DEAD

## Operation
- Reset: state=IDLE, direction=RIGHT, tick=0, q_count=0, counter=0, game_over=0.
- FSM: IDLE→RUN on `start`; RUN→PAUSED on `pause_btn`; PAUSED→RUN on `pause_btn`; RUN→DEAD on `bad_collision`; DEAD→IDLE on `start`. `start` ignored in RUN/PAUSED.
- Entering IDLE or DEAD: queue flushed, direction=RIGHT, counter=0.
- Press decode (RUN only; ignored in other states): priority up > right > down > left when several pulses coincide; one candidate per cycle.
- Reference heading `last` = queue tail if q_count>0, else `direction`.
- Candidate rejected if equal to `last`, reverse of `last` (UP↔DOWN, LEFT↔RIGHT), or queue full (newest dropped). Otherwise pushed.
- Tick counter runs in RUN only, holds in PAUSED. At count==period−1: counter→0, `tick`=1 next cycle, and if q_count>0 head pops into `direction` on the same edge.
- Push and pop in same cycle: both occur, q_count unchanged; `last` uses pre-pop tail.
- `bad_collision` has priority: same cycle as terminal count or `pause_btn` → DEAD, no tick, no pop.

## Timing
- `tick` and new `direction` become visible on the same edge; consumers sample both on the following edge.
- First tick after `start`: period cycles after RUN entry. Press-to-push latency: 1 cycle.
- Pause preserves counter phase; resume continues the count.

## Configuration
- `T06_SPEEDUP_EN` defined: period = max(TICK_DIV >> speed_level, 2), re-evaluated at each counter wrap.
- Not defined: period = TICK_DIV; `speed_level` ignored.

## Structure
- Package `t06_snake_pkg`: `dir_t` (UP/DOWN/LEFT/RIGHT encodings), `game_state_t`, function `dir_reverse`.
- Sub-module `t06_dir_queue`: synchronous FIFO with push/pop/flush, tail peek, count output.

## Test plan
- TICK_DIV=8: reset, `start` → state=01; `tick` every 8 cycles; direction=11.
- In RUN, press `up` then `left` within one tick → q_count=2; next tick direction=00; following tick direction=10.
- direction=11, empty queue, press `left` → rejected, q_count=0; press `right` → rejected.
- Five valid alternating presses (up, left, down, right, up) in one tick with QDEPTH=4 → q_count=4, fifth dropped.
- `pause_btn` at counter=5 for 20 cycles → no tick; resume → tick 3 cycles later.
- `bad_collision` coinciding with terminal count → state=11, game_over=1, no tick, q_count=0, direction=11; `start` → IDLE.
